// File: rtl/axil_pkg.sv
// Shared AXI4-Lite read-side definitions: response codes and default bus widths.
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    localparam int DEFAULT_WIDTH_ADDR = 32;
    localparam int DEFAULT_WIDTH_DATA = 32;

endpackage

// File: rtl/axil_cmd_fifo.sv
// Command FIFO holding read addresses waiting to be issued on AR.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter.
module axil_cmd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[PTR_W-1:0]];

    // Advance read/write pointers; natural overflow of the wrap bit gives seamless wrap-around.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is data only, so it is written without reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
    end

endmodule

// File: rtl/axil_read_master.sv
// AXI4-Lite read master: queues user read requests, issues them in order on
// AR with a cap on outstanding transactions, and registers each R response.
module axil_read_master
    import axil_pkg::*;
#(
    parameter int         WIDTH_ADDR      = DEFAULT_WIDTH_ADDR,
    parameter int         WIDTH_DATA      = DEFAULT_WIDTH_DATA,
    parameter int         CMD_DEPTH       = 4,
    parameter int         MAX_OUTSTANDING = 2,
    parameter logic [2:0] ARPROT          = 3'b000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  read_en,
    input  logic [WIDTH_ADDR-1:0] read_addr_in,
    output logic                  cmd_full,
    output logic                  cmd_overflow,
    output logic [WIDTH_DATA-1:0] read_data_out,
    output logic [1:0]            read_response_out,
    output logic                  read_done,
    output logic                  busy,
    output logic [7:0]            err_count,
    output logic [WIDTH_ADDR-1:0] araddr,
    output logic [2:0]            arprot,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [WIDTH_DATA-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    localparam int               OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push;
    logic [WIDTH_ADDR-1:0] fifo_head;
    logic [OUT_W-1:0]      outstanding;
    logic                  ar_hold;
    logic                  ar_fire;
    logic                  r_fire;

    // Saturating increment for the error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    axil_cmd_fifo #(
        .WIDTH (WIDTH_ADDR),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (ar_fire),
        .din     (read_addr_in),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Full is taken from the start-of-cycle state, so a push while full is
    // dropped even if the same edge pops an entry.
    assign cmd_full = fifo_full;
    assign push     = read_en && !fifo_full;

    // arvalid never looks at arready; ar_hold keeps a presented request up
    // until its handshake even if the outstanding limit is reached meanwhile.
    assign arvalid  = !fifo_empty && ((outstanding < OUT_MAX) || ar_hold);
    assign araddr   = fifo_head;
    assign arprot   = ARPROT;
    assign ar_fire  = arvalid && arready;

    // R beats are only accepted while something is in flight.
    assign rready   = (outstanding != '0);
    assign r_fire   = rvalid && rready;

    assign busy     = !fifo_empty || (outstanding != '0);

    // Remember that arvalid is presented but not yet accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ar_hold <= 1'b0;
        else          ar_hold <= arvalid && !arready;
    end

    // Track AR-accepted reads still waiting for their R beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
        end else if (ar_fire && !r_fire && (outstanding != OUT_MAX)) begin
            outstanding <= outstanding + OUT_W'(1);
        end else if (r_fire && !ar_fire && (outstanding != '0)) begin
            outstanding <= outstanding - OUT_W'(1);
        end
    end

    // Register completion results, status pulses and the error count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data_out     <= '0;
            read_response_out <= 2'b00;
            read_done         <= 1'b0;
            cmd_overflow      <= 1'b0;
            err_count         <= 8'd0;
        end else begin
            read_done    <= r_fire;
            cmd_overflow <= read_en && fifo_full;
            if (r_fire) begin
                read_data_out     <= rdata;
                read_response_out <= rresp;
                if (resp_e'(rresp) != OKAY) err_count <= sat_inc8(err_count);
            end
        end
    end

endmodule

// File: tb/tb_axil_read_master.sv
// Scoreboard bench for axil_read_master: a driver issues directed and random
// per-cycle stimulus into a queue; a monitor replays it through a queue-based
// reference model and compares every DUT output each cycle.
module tb_axil_read_master;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          read_en = 1'b0;
    logic [AW-1:0] read_addr_in = '0;
    logic          cmd_full;
    logic          cmd_overflow;
    logic [DW-1:0] read_data_out;
    logic [1:0]    read_response_out;
    logic          read_done;
    logic          busy;
    logic [7:0]    err_count;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic [1:0]    rresp = 2'b00;
    logic          rvalid = 1'b0;
    logic          rready;

    typedef struct packed {
        logic          rst;
        logic          ren;
        logic [AW-1:0] addr;
        logic          arr;
        logic          rv;
        logic [DW-1:0] rd;
        logic [1:0]    rr;
    } stim_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [1:0]    r;
    } rbeat_t;

    stim_t  stim_q[$];
    rbeat_t exp_r_q[$];
    bit     drv_done = 1'b0;
    int     checks = 0;
    int     failures = 0;

    always #5 clk = ~clk;

    axil_read_master #(
        .WIDTH_ADDR      (AW),
        .WIDTH_DATA      (DW),
        .CMD_DEPTH       (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .ARPROT          (3'b000)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .read_en           (read_en),
        .read_addr_in      (read_addr_in),
        .cmd_full          (cmd_full),
        .cmd_overflow      (cmd_overflow),
        .read_data_out     (read_data_out),
        .read_response_out (read_response_out),
        .read_done         (read_done),
        .busy              (busy),
        .err_count         (err_count),
        .araddr            (araddr),
        .arprot            (arprot),
        .arvalid           (arvalid),
        .arready           (arready),
        .rdata             (rdata),
        .rresp             (rresp),
        .rvalid            (rvalid),
        .rready            (rready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus, applied 2 time units after the rising edge.
    task automatic drive(input logic rst, input logic ren, input logic [AW-1:0] addr,
                         input logic arr, input logic rv, input logic [DW-1:0] rd,
                         input logic [1:0] rr);
        stim_t s;
        @(posedge clk);
        #2;
        reset_n      = !rst;
        read_en      = ren;
        read_addr_in = addr;
        arready      = arr;
        rvalid       = rv;
        rdata        = rd;
        rresp        = rr;
        s.rst = rst; s.ren = ren; s.addr = addr; s.arr = arr;
        s.rv = rv; s.rd = rd; s.rr = rr;
        stim_q.push_back(s);
    endtask

    task automatic idle(input logic arr, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, arr, 1'b0, '0, 2'b00);
    endtask

    // Driver: directed scenarios followed by random traffic.
    initial begin
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 2'b00);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 2'b00);

        // Single read at 0x10, response three cycles after the request.
        drive(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, '0, 2'b00);
        idle(1'b1, 2);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'hDEADBEEF, 2'b00);
        idle(1'b1, 3);

        // Overflow: five requests with arready low, then drain in order.
        for (int i = 0; i < 5; i++)
            drive(1'b0, 1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0, '0, 2'b00);
        idle(1'b0, 2);
        for (int i = 0; i < 14; i++)
            drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'hA000_0000 + 32'(i), 2'b00);

        // Outstanding limit: three requests, responses held back.
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b1, 32'h200 + 32'(i * 4), 1'b1, 1'b0, '0, 2'b00);
        idle(1'b1, 3);
        for (int i = 0; i < 6; i++)
            drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'hB000_0000 + 32'(i), 2'b00);

        // Error responses: SLVERR, DECERR, OKAY.
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b1, 32'h300 + 32'(i * 4), 1'b1, 1'b0, '0, 2'b00);
        idle(1'b1, 2);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'hC0, 2'b10);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'hC1, 2'b11);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'hC2, 2'b00);
        idle(1'b1, 2);

        // Simultaneous AR and R handshake with one read in flight.
        drive(1'b0, 1'b1, 32'h400, 1'b1, 1'b0, '0, 2'b00);
        drive(1'b0, 1'b1, 32'h404, 1'b1, 1'b0, '0, 2'b00);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'hD0, 2'b00);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'hD1, 2'b00);
        idle(1'b1, 2);

        // Reset with two reads outstanding, then stray R beats.
        drive(1'b0, 1'b1, 32'h500, 1'b1, 1'b0, '0, 2'b00);
        drive(1'b0, 1'b1, 32'h504, 1'b1, 1'b0, '0, 2'b00);
        drive(1'b0, 1'b1, 32'h508, 1'b1, 1'b0, '0, 2'b00);
        idle(1'b1, 2);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 32'hE0, 2'b00);
        for (int i = 0; i < 4; i++)
            drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'hE1, 2'b10);

        // Error counter saturation: sustained SLVERR traffic.
        for (int i = 0; i < 400; i++)
            drive(1'b0, 1'b1, $urandom(), 1'b1, 1'b1, $urandom(), 2'b10);
        idle(1'b1, 4);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic rst_r;
            rst_r = ($urandom_range(0, 499) == 0);
            drive(rst_r,
                  !rst_r && ($urandom_range(0, 1) == 1),
                  $urandom(),
                  ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 1) == 1),
                  $urandom(),
                  2'($urandom_range(0, 3)));
        end

        // Drain.
        for (int i = 0; i < 20; i++)
            drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'hF000_0000 + 32'(i), 2'b00);
        drv_done = 1'b1;
    end

    // Monitor: reference model plus per-cycle comparison.
    initial begin
        logic [AW-1:0] mq[$];
        int            outs;
        int            err;
        logic          prev_ovf;
        logic          prev_done;
        logic [DW-1:0] last_d;
        logic [1:0]    last_r;
        logic          e_full;
        logic          e_arv;
        logic          e_rr;
        logic          ar_hs;
        logic          r_hs;
        stim_t         s;
        rbeat_t        b;
        bit            fin;

        outs = 0; err = 0; prev_ovf = 1'b0; prev_done = 1'b0;
        last_d = '0; last_r = 2'b00; fin = 1'b0;

        while (!fin) begin
            @(posedge clk);
            #4;
            if (stim_q.size() == 0) begin
                if (drv_done) fin = 1'b1;
            end else begin
                s = stim_q.pop_front();
                if (s.rst) begin
                    chk("rst_arvalid", 64'(arvalid), 64'd0);
                    chk("rst_read_done", 64'(read_done), 64'd0);
                    chk("rst_cmd_overflow", 64'(cmd_overflow), 64'd0);
                    chk("rst_read_data_out", 64'(read_data_out), 64'd0);
                    chk("rst_read_response_out", 64'(read_response_out), 64'd0);
                    chk("rst_err_count", 64'(err_count), 64'd0);
                    chk("rst_cmd_full", 64'(cmd_full), 64'd0);
                    chk("rst_busy", 64'(busy), 64'd0);
                    chk("rst_rready", 64'(rready), 64'd0);
                    mq.delete();
                    exp_r_q.delete();
                    outs = 0; err = 0; prev_ovf = 1'b0; prev_done = 1'b0;
                    last_d = '0; last_r = 2'b00;
                end else begin
                    e_full = (mq.size() == DEPTH);
                    e_arv  = (mq.size() > 0) && (outs < MAXO);
                    e_rr   = (outs != 0);
                    chk("cmd_full", 64'(cmd_full), 64'(e_full));
                    chk("arvalid", 64'(arvalid), 64'(e_arv));
                    if (e_arv) chk("araddr", 64'(araddr), 64'(mq[0]));
                    chk("rready", 64'(rready), 64'(e_rr));
                    chk("busy", 64'(busy), 64'((mq.size() > 0) || (outs != 0)));
                    chk("arprot", 64'(arprot), 64'd0);
                    chk("cmd_overflow", 64'(cmd_overflow), 64'(prev_ovf));
                    chk("read_done", 64'(read_done), 64'(prev_done));
                    if (prev_done) begin
                        if (exp_r_q.size() == 0) begin
                            chk("r_scoreboard_empty", 64'(exp_r_q.size()), 64'd1);
                        end else begin
                            b = exp_r_q.pop_front();
                            last_d = b.d;
                            last_r = b.r;
                        end
                    end
                    chk("read_data_out", 64'(read_data_out), 64'(last_d));
                    chk("read_response_out", 64'(read_response_out), 64'(last_r));
                    chk("err_count", 64'(err_count), 64'(err));

                    ar_hs = e_arv && s.arr;
                    r_hs  = e_rr && s.rv;
                    if (ar_hs) void'(mq.pop_front());
                    if (s.ren && !e_full) mq.push_back(s.addr);
                    if (ar_hs) outs = outs + 1;
                    if (r_hs)  outs = outs - 1;
                    prev_ovf  = s.ren && e_full;
                    prev_done = r_hs;
                    if (r_hs) begin
                        b.d = s.rd;
                        b.r = s.rr;
                        exp_r_q.push_back(b);
                        if ((s.rr != 2'b00) && (err < 255)) err = err + 1;
                    end
                end
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axil_read_master.md
AXIL_READ_MASTER -- requirements
Module: axil_read_master

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- WIDTH_ADDR, 32, address width.
- WIDTH_DATA, 32, data width.
- CMD_DEPTH, 4, command FIFO entries; power of 2 and at least 2.
- MAX_OUTSTANDING, 2, maximum accepted AR without R; at least 1.
- ARPROT, 3'b000, constant value driven on arprot.

REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, the single clock.
- reset_n, in, 1, asynchronous active-low reset.
- read_en, in, 1, user read request strobe.
- read_addr_in, in, WIDTH_ADDR, request address.
- cmd_full, out, 1, command FIFO full.
- cmd_overflow, out, 1, one-cycle pulse when a request is dropped.
- read_data_out, out, WIDTH_DATA, last returned data.
- read_response_out, out, 2, last returned RRESP.
- read_done, out, 1, one-cycle pulse per completed read.
- busy, out, 1, FIFO non-empty or outstanding non-zero.
- err_count, out, 8, count of non-OKAY responses.
- araddr, out, WIDTH_ADDR, AXI read address.
- arprot, out, 3, AXI protection.
- arvalid, out, 1, AXI address valid.
- arready, in, 1, AXI address ready.
- rdata, in, WIDTH_DATA, AXI read data.
- rresp, in, 2, AXI read response.
- rvalid, in, 1, AXI read data valid.
- rready, out, 1, AXI read data ready.

REQ-003 The block SHALL use one clock, clk; reset_n SHALL be asynchronous and active-low.

Function
REQ-004 When read_en=1 and cmd_full=0 at a rising edge, read_addr_in SHALL be pushed into the FIFO.
REQ-005 When read_en=1 and cmd_full=1, the request SHALL be dropped and cmd_overflow SHALL be high in the next cycle only.
REQ-006 cmd_full SHALL be evaluated on the state at the start of the cycle; a push with a simultaneous pop while full SHALL be rejected.
REQ-007 FIFO pointers SHALL carry one extra wrap bit: empty when pointers are equal, full when only the wrap bit differs; wrap-around SHALL be seamless.
REQ-008 arvalid SHALL be derived without combinational dependence on arready: arvalid = FIFO non-empty AND (outstanding < MAX_OUTSTANDING, or arvalid already high); araddr SHALL equal the FIFO head.
REQ-009 Once high, arvalid and araddr SHALL stay stable until the arvalid&&arready handshake.
REQ-010 The handshake SHALL pop the FIFO; the next head, if present, SHALL be presented in the following cycle, allowing back-to-back issue.
REQ-011 Latency: with the FIFO empty and outstanding below MAX_OUTSTANDING, read_en in cycle 0 SHALL give arvalid=1 in cycle 1.
REQ-012 The outstanding counter, width clog2(MAX_OUTSTANDING+1), SHALL update as follows:
- +1 on AR handshake.
- -1 on R handshake.
- unchanged when both occur in the same cycle.
- never exceeds MAX_OUTSTANDING and never goes below 0.
REQ-013 rready SHALL equal (outstanding != 0); rvalid with outstanding=0 SHALL be ignored.
REQ-014 On an R handshake in cycle N, read_data_out and read_response_out SHALL be registered with rdata and rresp, and read_done SHALL be 1 in cycle N+1 only; these data outputs SHALL hold until the next R handshake.
REQ-015 Responses SHALL complete in issue order; there are no IDs.
REQ-016 err_count SHALL increment on each R handshake with rresp != OKAY and SHALL saturate at 255.
REQ-017 busy SHALL be combinational from the FIFO-empty flag and the outstanding counter.
REQ-018 arprot SHALL be the constant ARPROT.

Reset
REQ-019 While reset_n=0, the following SHALL all be 0, and the FIFO SHALL be empty:
- outputs: arvalid, read_done, cmd_overflow, read_data_out, read_response_out, err_count, cmd_full, busy, rready.
- internal: outstanding counter.
REQ-020 Reset mid-transaction SHALL discard queued and outstanding requests; R beats arriving after release SHALL be ignored because rready=0.

Structure
REQ-021 Package axil_pkg SHALL hold:
- resp enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
- default WIDTH_ADDR and WIDTH_DATA constants.
REQ-022 The FIFO SHALL be sub-module axil_cmd_fifo, parameterised by width and depth, with push, pop, head, full and empty.

Verification
REQ-023 Single read: read_en with addr 0x10, arready=1, rvalid 3 cycles later with rdata 0xDEADBEEF and OKAY -> arvalid in cycle 1; read_done once; read_data_out=0xDEADBEEF; err_count=0.
REQ-024 Overflow: arready=0, 5 read_en with CMD_DEPTH=4 -> cmd_full after the 4th; cmd_overflow pulse on the 5th; after arready=1, exactly 4 ARs are issued in order.
REQ-025 Outstanding limit: MAX_OUTSTANDING=2, arready=1, rvalid=0, 3 requests -> 2 AR handshakes; arvalid holds the 3rd address; the 3rd issues the cycle after the first R handshake.
REQ-026 Errors: 3 responses SLVERR, DECERR, OKAY -> err_count=2; read_response_out tracks each value.
REQ-027 Reset with 2 outstanding, then rvalid=1 -> rready=0; no read_done; busy=0.
REQ-028 Simultaneous AR and R handshake at outstanding=1 -> outstanding stays 1.
